reel_controller: RTL and testbench
==================================

# reel_controller

Sequencing controller for the slot machine's three digit reels. It starts all reels on a spin request and steps each reel mod-10 at its own stride. Stop requests, or an auto-stop timeout, freeze the reels left to right. Once all three are frozen it grades the result. It also time-multiplexes the reel digits onto the single per-digit 7-segment decoder and the 4-anode display.

## Interface
Parameters:
- SPIN_DIV, 5_000_000: clk cycles per reel step tick
- SCAN_DIV, 100_000: clk cycles per display digit slot
- AUTO_STOP, 150_000_000: clk cycles without a stop request before an automatic stop

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- spin_req  in  1  single-cycle pulse, debounced upstream
- stop_req  in  1  single-cycle pulse, debounced upstream
- reel_num  out  12  reel k digit on [4k+3:4k]; values 0–9 only
- reel_stop  out  3  bit k high when reel k is frozen
- busy  out  1  high in SPIN, STOP1 and STOP2
- win  out  1  all three reels equal
- pair  out  1  exactly two reels equal
- scan_num  out  4  digit code presented to the decoder; 4'hF means blank
- an  out  4  anode select, active-low one-hot

## Operation
- FSM states and transitions:
  - IDLE → SPIN on spin_req.
  - SPIN → STOP1 on a stop event (freezes reel 0).
  - STOP1 → STOP2 on a stop event (freezes reel 1).
  - STOP2 → RESULT on a stop event (freezes reel 2).
  - RESULT → SPIN on spin_req.
- Stop event: stop_req, or the auto-stop counter reaching AUTO_STOP−1.
- Auto-stop counter: clears on every state change; counts only in SPIN, STOP1 and STOP2.
- Reel stepping: on each step tick, every unfrozen reel advances by its stride (reel0 +1, reel1 +3, reel2 +7).
  - Compute in 5 bits; subtract 10 when the sum is ≥10.
  - Every stride is coprime with 10, so each reel visits all ten digits.
- Entering SPIN clears reel_stop to 000 and clears win and pair. Reel values are kept, not reset.
- Grading in RESULT:
  - win = (r0==r1 && r1==r2).
  - pair = !win && (r0==r1 || r1==r2 || r0==r2).
- Simultaneous events:
  - A stop event and a step tick in the same cycle: the reel being frozen keeps its pre-tick value. Reels still spinning step normally.
  - spin_req while busy is ignored.
  - stop_req in IDLE or RESULT is ignored.
  - spin_req and stop_req together in IDLE or RESULT: spin wins.
- Display scan:
  - The slot index 0..3 advances every SCAN_DIV cycles and wraps 3→0.
  - Slots 0–2 show reel 0–2. Slot 3 shows 4'hF (blank).
  - an = ~(1<<slot).

## Timing
- Reset values:
  - State IDLE.
  - reel_num 0; reel_stop 3'b111.
  - busy, win, pair all 0.
  - All counters 0, slot 0.
  - scan_num 0, an 4'b1110.
- Spin start: spin_req sampled at edge N gives busy=1 and reel_stop=000 after edge N.
- Freeze: a stop event at edge N sets the matching reel_stop bit after edge N, with the frozen value.
- Third stop at edge N:
  - reel_stop=111 and busy=0 after N.
  - win and pair are valid after edge N+1 (one-cycle registered grade).
- Step ticks:
  - The first tick comes SPIN_DIV cycles after entering SPIN.
  - The divider free-runs while busy and holds at 0 otherwise.
- scan_num and an change on the same edge, so there is no mixed-digit cycle.
- Reset asserted mid-spin: everything returns to the reset values immediately, with no partial grading.

## Structure
- Package slot_pkg holds:
  - The state enum (IDLE, SPIN, STOP1, STOP2, RESULT).
  - NUM_REELS=3.
  - The stride constants {1,3,7}.
  - DIGIT_BLANK=4'hF.
- Sub-module reel_counter: a 4-bit mod-10 stepper with a stride parameter and tick/hold inputs. It is instantiated three times.
- The FSM, the dividers, the grading logic and the scan mux live in the top module.

## Test plan
- Reset with SPIN_DIV=4, SCAN_DIV=2 → reel_num=0, reel_stop=111, an cycles 1110, 1101, 1011, 0111 every 2 cycles, slot 3 scan_num=F.
- spin_req, then 3 ticks → reels 3, 9, 1. Then stop_req ×3 with no ticks between → reel_stop goes 001, 011, 111; win=0, pair=0.
- Force a result of 7,7,7 via tick-aligned stops → win=1, pair=0 one cycle after reel_stop=111. A result of 2,5,2 → pair=1.
- stop_req coincident with a tick in SPIN → reel0 keeps its pre-tick value; reels 1 and 2 advance.
- No stop_req with AUTO_STOP=20 → STOP1 after 20 cycles, STOP2 after 20 more, RESULT after 20 more. spin_req mid-spin is ignored.
- rst_n low for 1 cycle while in STOP1 → all outputs return to reset values; a following spin_req starts a fresh spin.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine reel controller.
package slot_pkg;

    localparam int unsigned NUM_REELS = 3;
    localparam int unsigned DIGIT_W   = 4;

    localparam int unsigned STRIDE_R0 = 1;
    localparam int unsigned STRIDE_R1 = 3;
    localparam int unsigned STRIDE_R2 = 7;

    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        STOP1,
        STOP2,
        RESULT
    } state_e;

    // Per-reel stride lookup, usable in parameter overrides.
    function automatic int unsigned reel_stride(input int unsigned k);
        case (k)
            0:       return STRIDE_R0;
            1:       return STRIDE_R1;
            default: return STRIDE_R2;
        endcase
    endfunction

endpackage

// File: rtl/reel_counter.sv
// Single mod-10 reel digit; advances by STRIDE on each tick unless held.
module reel_counter
    import slot_pkg::*;
#(
    parameter int unsigned STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               hold_i,
    output logic [DIGIT_W-1:0] digit_o
);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [DIGIT_W:0]   sum_c;

    always_comb begin
        sum_c   = 5'(digit_q) + 5'(STRIDE);
        digit_d = digit_q;
        if (tick_i && !hold_i) begin
            digit_d = (sum_c >= 5'd10) ? 4'(sum_c - 5'd10) : 4'(sum_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/reel_controller.sv
// Three-reel spin/stop sequencer with result grading and a 4-slot display scan.
module reel_controller
    import slot_pkg::*;
#(
    parameter int unsigned SPIN_DIV  = 5_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned AUTO_STOP = 150_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spin_req,
    input  logic                           stop_req,
    output logic [NUM_REELS*DIGIT_W-1:0]   reel_num,
    output logic [NUM_REELS-1:0]           reel_stop,
    output logic                           busy,
    output logic                           win,
    output logic                           pair,
    output logic [DIGIT_W-1:0]             scan_num,
    output logic [3:0]                     an
);

    localparam int unsigned SPIN_W = $clog2(SPIN_DIV + 1);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned AUTO_W = $clog2(AUTO_STOP + 1);

    state_e               state_q, state_d;
    logic [SPIN_W-1:0]    div_q, div_d;
    logic [AUTO_W-1:0]    auto_q, auto_d;
    logic [SCAN_W-1:0]    sdiv_q, sdiv_d;
    logic [1:0]           slot_q, slot_d;
    logic [NUM_REELS-1:0] reel_stop_q, reel_stop_d;
    logic                 busy_q, busy_d;
    logic                 win_q, win_d;
    logic                 pair_q, pair_d;
    logic [DIGIT_W-1:0]   scan_num_q, scan_num_d;
    logic [3:0]           an_q, an_d;

    logic                 busy_now, spin_tick, scan_tick, auto_hit, stop_evt;
    logic [NUM_REELS-1:0] freeze;
    logic [DIGIT_W-1:0]   digit [NUM_REELS];

    assign busy_now  = (state_q == SPIN) || (state_q == STOP1) || (state_q == STOP2);
    assign spin_tick = busy_now && (div_q == SPIN_W'(SPIN_DIV - 1));
    assign scan_tick = (sdiv_q == SCAN_W'(SCAN_DIV - 1));
    assign auto_hit  = (auto_q == AUTO_W'(AUTO_STOP - 1));
    assign stop_evt  = busy_now && (stop_req || auto_hit);

    // Next state and which reel (if any) freezes this cycle.
    always_comb begin
        state_d = state_q;
        freeze  = '0;
        case (state_q)
            IDLE, RESULT: if (spin_req) state_d = SPIN;
            SPIN:  if (stop_evt) begin state_d = STOP1;  freeze = 3'b001; end
            STOP1: if (stop_evt) begin state_d = STOP2;  freeze = 3'b010; end
            STOP2: if (stop_evt) begin state_d = RESULT; freeze = 3'b100; end
            default: state_d = IDLE;
        endcase
    end

    // Counters, freeze mask, grading and scan mux.
    always_comb begin
        div_d       = '0;
        auto_d      = '0;
        reel_stop_d = reel_stop_q | freeze;
        busy_d      = (state_d == SPIN) || (state_d == STOP1) || (state_d == STOP2);
        win_d       = win_q;
        pair_d      = pair_q;
        sdiv_d      = scan_tick ? '0 : sdiv_q + SCAN_W'(1);
        slot_d      = scan_tick ? slot_q + 2'd1 : slot_q;
        an_d        = ~(4'b0001 << slot_d);
        scan_num_d  = DIGIT_BLANK;

        if (busy_now) begin
            div_d = spin_tick ? '0 : div_q + SPIN_W'(1);
            if (state_d == state_q) auto_d = auto_q + AUTO_W'(1);
        end

        if (state_d == SPIN) begin
            reel_stop_d = '0;
            win_d       = 1'b0;
            pair_d      = 1'b0;
        end else if (state_q == RESULT) begin
            win_d  = (digit[0] == digit[1]) && (digit[1] == digit[2]);
            pair_d = !win_d && ((digit[0] == digit[1]) || (digit[1] == digit[2]) ||
                                (digit[0] == digit[2]));
        end

        case (slot_d)
            2'd0:    scan_num_d = digit[0];
            2'd1:    scan_num_d = digit[1];
            2'd2:    scan_num_d = digit[2];
            default: scan_num_d = DIGIT_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            auto_q      <= '0;
            sdiv_q      <= '0;
            slot_q      <= '0;
            reel_stop_q <= '1;
            busy_q      <= 1'b0;
            win_q       <= 1'b0;
            pair_q      <= 1'b0;
            scan_num_q  <= '0;
            an_q        <= 4'b1110;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            auto_q      <= auto_d;
            sdiv_q      <= sdiv_d;
            slot_q      <= slot_d;
            reel_stop_q <= reel_stop_d;
            busy_q      <= busy_d;
            win_q       <= win_d;
            pair_q      <= pair_d;
            scan_num_q  <= scan_num_d;
            an_q        <= an_d;
        end
    end

    // A reel being frozen holds its pre-tick value even if a tick lands now.
    for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
        reel_counter #(
            .STRIDE(reel_stride(k))
        ) u_reel (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_i  (spin_tick),
            .hold_i  (reel_stop_q[k] | freeze[k]),
            .digit_o (digit[k])
        );
        assign reel_num[DIGIT_W*k +: DIGIT_W] = digit[k];
    end

    assign reel_stop = reel_stop_q;
    assign busy      = busy_q;
    assign win       = win_q;
    assign pair      = pair_q;
    assign scan_num  = scan_num_q;
    assign an        = an_q;

endmodule

// File: tb/tb_reel_controller.sv
// Directed and randomized checks of reel_controller against a behavioural model.
module tb_reel_controller;

    localparam int unsigned SPIN_DIV  = 4;
    localparam int unsigned SCAN_DIV  = 2;
    localparam int unsigned AUTO_STOP = 20;

    logic        clk;
    logic        rst_n;
    logic        spin_req;
    logic        stop_req;
    logic [11:0] reel_num;
    logic [2:0]  reel_stop;
    logic        busy, win, pair;
    logic [3:0]  scan_num;
    logic [3:0]  an;

    reel_controller #(
        .SPIN_DIV  (SPIN_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .AUTO_STOP (AUTO_STOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spin_req  (spin_req),
        .stop_req  (stop_req),
        .reel_num  (reel_num),
        .reel_stop (reel_stop),
        .busy      (busy),
        .win       (win),
        .pair      (pair),
        .scan_num  (scan_num),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: phase 0 idle, 1 spin, 2 stop1, 3 stop2, 4 result.
    int       m_phase;
    int       m_reel [3];
    bit [2:0] m_frz;
    int       m_div, m_auto, m_sdiv, m_slot, m_snum;
    bit       m_win, m_pair;
    int       stride [3] = '{1, 3, 7};

    task automatic model_reset();
        m_phase = 0;
        m_reel  = '{0, 0, 0};
        m_frz   = 3'b111;
        m_div   = 0;
        m_auto  = 0;
        m_sdiv  = 0;
        m_slot  = 0;
        m_snum  = 0;
        m_win   = 0;
        m_pair  = 0;
    endtask

    task automatic model_step(input bit sp, input bit st);
        bit mbusy, tick, sev, enter;
        int nphase;
        int oreel [3];
        mbusy  = (m_phase >= 1) && (m_phase <= 3);
        tick   = mbusy && (m_div == SPIN_DIV - 1);
        sev    = mbusy && (st || (m_auto == AUTO_STOP - 1));
        enter  = !mbusy && sp;
        oreel  = m_reel;
        nphase = enter ? 1 : (sev ? m_phase + 1 : m_phase);
        for (int k = 0; k < 3; k++)
            if (tick && !m_frz[k] && !(sev && k == m_phase - 1))
                m_reel[k] = (m_reel[k] + stride[k]) % 10;
        if (enter) m_frz = 3'b000;
        else if (sev) m_frz[m_phase - 1] = 1'b1;
        m_div  = mbusy ? (tick ? 0 : m_div + 1) : 0;
        m_auto = (nphase != m_phase || !mbusy) ? 0 : m_auto + 1;
        if (enter) begin
            m_win  = 0;
            m_pair = 0;
        end else if (m_phase == 4) begin
            m_win  = (oreel[0] == oreel[1]) && (oreel[1] == oreel[2]);
            m_pair = !m_win && (oreel[0] == oreel[1] || oreel[1] == oreel[2] ||
                                oreel[0] == oreel[2]);
        end
        if (m_sdiv == SCAN_DIV - 1) begin
            m_sdiv = 0;
            m_slot = (m_slot + 1) % 4;
        end else begin
            m_sdiv++;
        end
        m_snum  = (m_slot == 3) ? 15 : oreel[m_slot];
        m_phase = nphase;
    endtask

    task automatic compare_all();
        check_eq("reel_num",  32'(reel_num),  32'(m_reel[2] * 256 + m_reel[1] * 16 + m_reel[0]));
        check_eq("reel_stop", 32'(reel_stop), 32'(m_frz));
        check_eq("busy",      32'(busy),      32'((m_phase >= 1 && m_phase <= 3) ? 1 : 0));
        check_eq("win",       32'(win),       32'(m_win));
        check_eq("pair",      32'(pair),      32'(m_pair));
        check_eq("scan_num",  32'(scan_num),  32'(m_snum));
        check_eq("an",        32'(an),        32'(15 - (1 << m_slot)));
    endtask

    // One clock: drive after a falling edge, model at the rising edge, compare at the next fall.
    task automatic cycle(input bit sp, input bit st);
        spin_req = sp;
        stop_req = st;
        @(posedge clk);
        model_step(sp, st);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        spin_req = 1'b0;
        stop_req = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        rst_n    = 1'b0;
        spin_req = 1'b0;
        stop_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        check_eq("rst_stop", 32'(reel_stop), 32'h7);
        check_eq("rst_an",   32'(an),        32'he);
        idle(8);

        // Three ticks then three back-to-back stops: 3,9,1 graded as no match.
        cycle(1'b1, 1'b0);
        check_eq("spin_busy", 32'(busy), 32'h1);
        idle(12);
        check_eq("reels_391", 32'(reel_num), 32'h193);
        cycle(1'b0, 1'b1);
        check_eq("stop_001", 32'(reel_stop), 32'h1);
        cycle(1'b0, 1'b1);
        check_eq("stop_011", 32'(reel_stop), 32'h3);
        cycle(1'b0, 1'b1);
        check_eq("stop_111", 32'(reel_stop), 32'h7);
        idle(1);
        check_eq("win_391",  32'(win),  32'h0);
        check_eq("pair_391", 32'(pair), 32'h0);

        // Stops timed to land on 7,7,7.
        cycle(1'b1, 1'b0);
        idle(16);
        cycle(1'b0, 1'b1);
        idle(7);
        cycle(1'b0, 1'b1);
        idle(7);
        cycle(1'b0, 1'b1);
        check_eq("reels_777", 32'(reel_num), 32'h777);
        check_eq("busy_777",  32'(busy),     32'h0);
        idle(1);
        check_eq("win_777",  32'(win),  32'h1);
        check_eq("pair_777", 32'(pair), 32'h0);

        // Auto-stop only, with ignored spin requests mid-spin.
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            cycle(i == 5 || i == 25, 1'b0);
            if (i == 19) check_eq("auto_pre",  32'(reel_stop), 32'h0);
            if (i == 20) check_eq("auto_s1",   32'(reel_stop), 32'h1);
            if (i == 40) check_eq("auto_s2",   32'(reel_stop), 32'h3);
            if (i == 60) check_eq("auto_s3",   32'(reel_stop), 32'h7);
            if (i == 60) check_eq("auto_busy", 32'(busy),      32'h0);
        end
        cycle(1'b0, 1'b1);
        check_eq("res_stop_ign", 32'(busy), 32'h0);
        cycle(1'b1, 1'b1);
        check_eq("spin_wins",    32'(reel_stop), 32'h0);

        // Reset while in STOP1.
        idle(5);
        cycle(1'b0, 1'b1);
        idle(2);
        check_eq("in_stop1", 32'(reel_stop), 32'h1);
        do_reset();
        check_eq("rst2_num",  32'(reel_num),  32'h0);
        check_eq("rst2_stop", 32'(reel_stop), 32'h7);
        check_eq("rst2_win",  32'(win),       32'h0);

        // Fresh spin to 2,5,2; first stop lands on a tick.
        cycle(1'b1, 1'b0);
        check_eq("fresh_busy", 32'(busy), 32'h1);
        idle(11);
        cycle(1'b0, 1'b1);
        check_eq("tick_stop", 32'(reel_num), 32'h192);
        idle(8);
        cycle(1'b0, 1'b1);
        idle(3);
        cycle(1'b0, 1'b1);
        check_eq("reels_252", 32'(reel_num), 32'h252);
        idle(1);
        check_eq("pair_252", 32'(pair), 32'h1);
        check_eq("win_252",  32'(win),  32'h0);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else cycle($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
